// File: rtl/dtree_eval_sched.sv
// Round-robin scheduler that time-shares one slow combinational decision-tree
// classifier between NREQ requesters and returns each class with its requester ID.
module dtree_eval_sched #(
    parameter int NREQ   = 2,
    parameter int NFEAT  = 5,
    parameter int FW     = 8,
    parameter int CW     = 1,
    parameter int SETTLE = 2,
    parameter int IDW    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*NFEAT*FW-1:0]  req_feat,
    output logic [NFEAT*FW-1:0]       tree_x,
    input  logic [CW-1:0]             tree_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [CW-1:0]             res_class,
    output logic [IDW-1:0]            res_id,
    output logic                      busy,
    output logic [15:0]               eval_count
);

    localparam int SW   = NFEAT * FW;
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE - 1);

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [SW-1:0]   tree_x_q, tree_x_d;
    logic            res_valid_q, res_valid_d;
    logic [CW-1:0]   res_class_q, res_class_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [15:0]     eval_count_q, eval_count_d;

    logic [IDW-1:0]  grant;
    logic            grant_any;
    logic [NREQ-1:0] ready_vec;

    // Round-robin search: scanning offsets downward lets the smallest offset from rr_q win.
    always_comb begin
        int idx;
        grant     = {IDW{1'b0}};
        grant_any = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (req_valid[idx]) begin
                grant     = IDW'(idx);
                grant_any = 1'b1;
            end else begin
                grant     = grant;
                grant_any = grant_any;
            end
        end
    end

    // Accept strobe: only the granted requester sees ready, and only while idle.
    always_comb begin
        ready_vec = {NREQ{1'b0}};
        if ((state_q == ST_IDLE) && grant_any) begin
            ready_vec[grant] = 1'b1;
        end else begin
            ready_vec = {NREQ{1'b0}};
        end
    end

    // Next-state logic for the evaluation sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        tree_x_d     = tree_x_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_id_d     = res_id_q;
        eval_count_d = eval_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    tree_x_d = req_feat[int'(grant) * SW +: SW];
                    res_id_d = grant;
                    cnt_d    = CNT_INIT;
                    if (int'(grant) == NREQ - 1) begin
                        rr_d = {IDW{1'b0}};
                    end else begin
                        rr_d = grant + IDW'(1);
                    end
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // tree_x is frozen here so the printed logic sees a stable input.
                if (cnt_q != {CNTW{1'b0}}) begin
                    cnt_d = cnt_q - CNTW'(1);
                end else begin
                    res_class_d = tree_out;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (eval_count_q != 16'hFFFF) begin
                        eval_count_d = eval_count_q + 16'd1;
                    end else begin
                        eval_count_d = eval_count_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNTW{1'b0}};
            rr_q         <= {IDW{1'b0}};
            tree_x_q     <= {SW{1'b0}};
            res_valid_q  <= 1'b0;
            res_class_q  <= {CW{1'b0}};
            res_id_q     <= {IDW{1'b0}};
            eval_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            tree_x_q     <= tree_x_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_id_q     <= res_id_d;
            eval_count_q <= eval_count_d;
        end
    end

    assign req_ready  = ready_vec;
    assign tree_x     = tree_x_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_id     = res_id_q;
    assign busy       = (state_q != ST_IDLE);
    assign eval_count = eval_count_q;

endmodule

// File: tb/tb_dtree_eval_sched.sv
// Self-checking bench for dtree_eval_sched: transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_dtree_eval_sched;
    localparam int NREQ = 2, NFEAT = 5, FW = 8, CW = 1, SETTLE = 2, IDW = 1;
    localparam int SW = NFEAT * FW;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid, req_ready;
    logic [NREQ*SW-1:0]     req_feat;
    logic [SW-1:0]          tree_x;
    logic [CW-1:0]          tree_out;
    logic                   res_valid, res_ready;
    logic [CW-1:0]          res_class;
    logic [IDW-1:0]         res_id;
    logic                   busy;
    logic [15:0]            eval_count;
    logic                   ovr;

    always #5 clk = ~clk;

    dtree_eval_sched #(.NREQ(NREQ), .NFEAT(NFEAT), .FW(FW), .CW(CW), .SETTLE(SETTLE), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_feat(req_feat), .tree_x(tree_x), .tree_out(tree_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_id(res_id), .busy(busy), .eval_count(eval_count)
    );

    // Toy tree: class 1 when feature0 < feature1, optionally inverted to emulate glitches.
    assign tree_out = ((tree_x[7:0] < tree_x[15:8]) ? 1'b1 : 1'b0) ^ ovr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting for work, 1 = settling, 2 = result offered.
    int            m_phase = 0;
    int            m_left  = 0;
    int            m_rr    = 0;
    int            m_id    = 0;
    logic [SW-1:0] m_x     = '0;
    logic [CW-1:0] m_class = '0;
    bit            m_valid = 1'b0;
    logic [15:0]   m_count = 16'd0;
    int            grants[$];

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (rr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_rr = 0; m_id = 0;
            m_x = '0; m_class = '0; m_valid = 1'b0; m_count = 16'd0;
        end else begin
            case (m_phase)
                0: begin
                    g = pick(req_valid, m_rr);
                    if (g >= 0) begin
                        m_x     = req_feat[g*SW +: SW];
                        m_id    = g;
                        m_left  = SETTLE;
                        m_rr    = (g + 1) % NREQ;
                        m_phase = 1;
                        grants.push_back(g);
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_class = tree_out;
                        m_valid = 1'b1;
                        m_phase = 2;
                    end
                end
                default: begin
                    if (res_ready) begin
                        m_valid = 1'b0;
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Compare process: every cycle, shortly after the falling edge.
    always begin
        logic [NREQ-1:0] er;
        int g;
        @(negedge clk);
        #1;
        if (chk_en) begin
            er = '0;
            if (m_phase == 0) begin
                g = pick(req_valid, m_rr);
                if (g >= 0) er[g] = 1'b1;
            end
            chk("req_ready", req_ready, er);
            chk("tree_x", tree_x, m_x);
            chk("res_valid", res_valid, m_valid);
            chk("res_class", res_class, m_class);
            chk("res_id", res_id, m_id[IDW-1:0]);
            chk("busy", busy, m_phase != 0);
            chk("eval_count", eval_count, m_count);
        end
    end

    task automatic rand_feat();
        for (int b = 0; b < NREQ * NFEAT; b++) req_feat[b*FW +: FW] = 8'($urandom_range(0, 255));
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("drain_idle", busy, 1'b0);
    endtask

    task automatic stab(input logic first, input logic last, input logic [CW-1:0] exp);
        @(negedge clk);
        rand_feat();
        req_feat[7:0] = 8'd5; req_feat[15:8] = 8'd9;
        req_valid = 2'b01; res_ready = 1'b1; ovr = 1'b0;
        @(negedge clk); req_valid = '0; ovr = first;
        @(negedge clk); ovr = last;
        @(negedge clk); #2;
        chk("stab_valid", res_valid, 1'b1);
        chk("stab_class", res_class, exp);
        ovr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_feat = '0; res_ready = 1'b0; ovr = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        // Reset values
        @(negedge clk); rst_n = 1'b1; #2;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_tree_x", tree_x, 40'h0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", eval_count, 16'd0);

        // Single request from requester 0
        @(negedge clk);
        req_feat[SW-1:0] = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        req_valid = 2'b01; res_ready = 1'b1; #2;
        chk("single_ready", req_ready, 2'b01);
        @(negedge clk); req_valid = '0; #2;
        chk("single_tree_x", tree_x, 40'h32281E140A);
        chk("single_busy", busy, 1'b1);
        chk("single_v0", res_valid, 1'b0);
        @(negedge clk); #2;
        chk("single_v1", res_valid, 1'b0);
        @(negedge clk); #2;
        chk("single_v2", res_valid, 1'b1);
        chk("single_class", res_class, 1'b1);
        chk("single_id", res_id, 1'b0);
        @(negedge clk); #2;
        chk("single_done", res_valid, 1'b0);
        chk("single_count", eval_count, 16'd1);
        chk("single_keep_x", tree_x, 40'h32281E140A);

        // Reset in the middle of settling; pointer currently points at requester 1
        @(negedge clk); req_valid = 2'b01;
        @(negedge clk); req_valid = '0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #2;
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_x", tree_x, 40'h0);
        chk("mid_rst_count", eval_count, 16'd0);
        repeat (3) @(negedge clk);
        #2 chk("mid_rst_no_result", res_valid, 1'b0);

        // Continuous contention: strict alternation starting at requester 0
        @(negedge clk);
        grants.delete();
        rand_feat(); req_valid = 2'b11; res_ready = 1'b1;
        for (int i = 0; i < 60 && grants.size() < 4; i++) @(negedge clk);
        req_valid = '0;
        chk("rr_count", grants.size(), 4);
        if (grants.size() >= 4) begin
            chk("rr_g0", grants[0], 0);
            chk("rr_g1", grants[1], 1);
            chk("rr_g2", grants[2], 0);
            chk("rr_g3", grants[3], 1);
        end
        drain();

        // Backpressure in HOLD
        @(negedge clk);
        rand_feat(); req_valid = 2'b10; res_ready = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        res_ready = 1'b1; req_valid = '0;
        @(negedge clk); #2;
        chk("bp_release", res_valid, 1'b0);
        drain();

        // Capture uses tree_out from the final settle cycle only
        stab(1'b1, 1'b0, 1'b1);
        stab(1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_feat();
            req_valid = 2'($urandom_range(0, 3));
            res_ready = ($urandom_range(0, 3) != 0);
            ovr = 1'($urandom_range(0, 1));
        end
        ovr = 1'b0;
        drain();

        // Saturation: preload the counter near its ceiling
        @(negedge clk);
        force dut.eval_count_q = 16'hFFFD;
        m_count = 16'hFFFD;
        #3 release dut.eval_count_q;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); rand_feat(); req_valid = 2'b01; res_ready = 1'b1;
            @(negedge clk); req_valid = '0;
            repeat (4) @(negedge clk);
        end
        #2 chk("sat_count", eval_count, 16'hFFFF);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/dtree_eval_sched.md
Name: dtree_eval_sched

Overview:
- Round-robin scheduler that shares one combinational printed decision-tree classifier (NFEAT features of FW bits in, CW-bit class out) between NREQ requesters.
- Registers the granted sample onto the tree inputs and waits a fixed settle time for the slow printed logic.
- Captures the class and returns it with the requester ID over a valid/ready result port.
- Sits between the feature sources (sensor front-ends or a sample FIFO) and the tree.

Parameters:
- NREQ, 2, number of requesters (≥2)
- NFEAT, 5, features per sample
- FW, 8, bits per feature
- CW, 1, class output width
- SETTLE, 2, cycles the tree inputs are held stable before capture (≥1)
- IDW, 1, requester ID width, equal to clog2(NREQ)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester sample valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_feat  in  NREQ*NFEAT*FW  samples; requester i at bits [i*NFEAT*FW +: NFEAT*FW]; feature j at offset j*FW
- tree_x  out  NFEAT*FW  registered features to the tree; feature j at [j*FW +: FW]
- tree_out  in  CW  combinational class from the tree
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_class  out  CW  captured class
- res_id  out  IDW  requester that issued the sample
- busy  out  1  high whenever state != IDLE
- eval_count  out  16  completed results, saturating

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; req_ready=0; tree_x=0; res_valid=0; res_class=0; res_id=0; busy=0; eval_count=0; rr pointer=0. Any in-flight sample is discarded without a result.
- FSM states: IDLE, SETTLE_WAIT, HOLD.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr pointer upward with wrap (mod NREQ).
  - req_ready[grant]=1 combinationally. All other req_ready bits are 0, and req_ready=0 outside IDLE or when no request is valid.
  - On the accepting edge: tree_x<=req_feat slice of grant; res_id<=grant; cnt<=SETTLE-1; rr pointer<=(grant+1) mod NREQ; go to SETTLE_WAIT.
- SETTLE_WAIT:
  - tree_x held constant.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: res_class<=tree_out; res_valid<=1; go to HOLD.
- HOLD:
  - res_valid, res_class and res_id held stable until res_valid&&res_ready.
  - On that edge: res_valid<=0; eval_count<=eval_count+1, saturating at 16'hFFFF; go to IDLE.
- Latency: accept edge at cycle 0 → res_valid high after the edge at cycle SETTLE, visible during cycle SETTLE+1. A res_ready already high costs one more cycle.
- Throughput: one evaluation in flight. Minimum spacing between accepts is SETTLE+2 cycles.
- tree_x keeps the last sample after completion. There is no return to zero, which avoids extra switching in printed logic.
- Requests that arrive while busy wait with req_ready=0. A requester may drop req_valid before it is granted; no state is kept for ungranted requests.
- res_ready is ignored outside HOLD.
- Simultaneous valid requests are served strictly round-robin: no requester is granted twice while another holds valid continuously.

Test Plan:
- Reset mid-SETTLE_WAIT: rst_n=0 for 1 cycle → all outputs zero next cycle, no res_valid, eval_count=0; the next request is granted to requester 0.
- Single request (SETTLE=2): req0 features {10,20,30,40,50}, tree model returns 1, res_ready=1 → tree_x=0x3228_1E14_0A after the accept edge; res_valid visible 3 cycles after the accept edge with res_class=1, res_id=0; eval_count=1.
- Both requesters valid continuously for 4 evaluations → grant order 0,1,0,1; res_id sequence matches; each req_ready pulse lasts 1 cycle.
- Backpressure: res_ready=0 for 5 cycles in HOLD → res_valid/res_class/res_id stable, req_ready stays 0; the result releases on the first res_ready=1 edge.
- Stability: tree_out changes during SETTLE_WAIT before the final cycle → the captured class equals the tree_out value in the cnt==0 cycle.
- Saturation: force 65536 completions (or preload via backdoor) → eval_count stays at 0xFFFF.
